// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
// Port A is the CPU MEM stage, port B the interrupt context-save engine.
// A wins contended cycles. B can hold the memory across cycles with b_lock.
// Optional macro DMEM_ARB_STARVE_EN compiles in a starvation counter.
// With that counter, B wins a contended cycle after STARVE_LIMIT denied
// cycles in a row. Read data returns one cycle after the grant.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [3:0]    a_mask,
  input  logic [31:0]   a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [3:0]    b_mask,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          mem_ceb,
  output logic          mem_web,
  output logic [AW-1:0] mem_a,
  output logic [3:0]    mem_mask,
  output logic [31:0]   mem_d,
  input  logic [31:0]   mem_q
);

  typedef enum logic {IDLE, LOCK_B} state_t;

  state_t state_reg, state_next;
  logic   rd_a_reg, rd_b_reg;
  logic   force_b;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_reg;

  assign force_b = (starve_cnt_reg == LIMIT);

  // Count consecutive denied B cycles, saturating; any B grant clears it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt_reg <= '0;
    end else if (b_gnt) begin
      starve_cnt_reg <= '0;
    end else if (b_req && (starve_cnt_reg != LIMIT)) begin
      starve_cnt_reg <= starve_cnt_reg + CW'(1);
    end
  end
`else
  // Strict priority: this is false for every legal (positive) limit
  assign force_b = (STARVE_LIMIT < 0);
`endif

  // State register for the B-lock FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Combinational grant decision and next state; nothing is granted in reset
  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    state_next = state_reg;
    if (resetn) begin
      case (state_reg)
        IDLE: begin
          if (b_req && (!a_req || force_b)) begin
            b_gnt = 1'b1;
          end else if (a_req) begin
            a_gnt = 1'b1;
          end
          if (b_gnt && b_lock) begin
            state_next = LOCK_B;
          end
        end
        LOCK_B: begin
          b_gnt = b_req;
          if (!b_lock) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Steer the granted port onto the memory bus; idle bus is all zeros
  always_comb begin
    mem_ceb  = 1'b1;
    mem_web  = 1'b1;
    mem_a    = '0;
    mem_mask = 4'h0;
    mem_d    = 32'h0;
    if (a_gnt) begin
      mem_ceb  = 1'b0;
      mem_web  = ~a_we;
      mem_a    = a_addr;
      mem_mask = a_mask;
      mem_d    = a_wdata;
    end else if (b_gnt) begin
      mem_ceb  = 1'b0;
      mem_web  = ~b_we;
      mem_a    = b_addr;
      mem_mask = b_mask;
      mem_d    = b_wdata;
    end
  end

  // Remember which port owns the read data coming back next cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_a_reg <= 1'b0;
      rd_b_reg <= 1'b0;
    end else begin
      rd_a_reg <= a_gnt & ~a_we;
      rd_b_reg <= b_gnt & ~b_we;
    end
  end

  // Reset also suppresses a return that is already in flight
  assign a_rvalid = resetn & rd_a_reg;
  assign b_rvalid = resetn & rd_b_reg;
  assign a_rdata  = a_rvalid ? mem_q : 32'h0;
  assign b_rdata  = b_rvalid ? mem_q : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied port-B request cycles before port B is forced to win.
REQ-002 Parameter AW, default 10: word-address width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 a_req / a_we  input  1 each  CPU MEM-stage access request / write (1) or read (0).
REQ-006 a_addr  input  AW; a_mask  input  4; a_wdata  input  32  CPU word address, byte enables, write data.
REQ-007 a_gnt  output  1  CPU access accepted this cycle.
REQ-008 a_rvalid  output  1; a_rdata  output  32  CPU read return.
REQ-009 b_req / b_we / b_lock  input  1 each  interrupt context-save engine request / write / hold ownership.
REQ-010 b_addr  input  AW; b_mask  input  4; b_wdata  input  32  context engine address, byte enables, write data.
REQ-011 b_gnt  output  1; b_rvalid  output  1; b_rdata  output  32  context engine grant and read return.
REQ-012 mem_ceb / mem_web  output  1 each  memory chip enable / write enable, both active-low.
REQ-013 mem_a  output  AW; mem_mask  output  4; mem_d  output  32; mem_q  input  32  memory address, mask, write data, read data.

Function
REQ-014 Grants are combinational and issued in the request cycle; at most one grant per cycle; a grant is issued only to an asserted request.
REQ-015 Memory outputs carry the granted port's address, mask and data, with mem_ceb=0 and mem_web=~we; with no grant: mem_ceb=1, mem_web=1, and mem_a, mem_mask, mem_d all 0.
REQ-016 State IDLE: only one port requesting -> that port wins; both requesting -> A wins, unless the starvation rule (REQ-019) forces B.
REQ-017 IDLE -> LOCK_B on the clock edge ending a cycle in which B is granted with b_lock=1.
REQ-018 LOCK_B: a_gnt=0 and b_gnt=b_req; on the first edge with b_lock=0 -> IDLE, and the B request in that same cycle is still granted.
REQ-019 Starvation counter, width clog2(STARVE_LIMIT+1): increments each cycle b_req=1 and b_gnt=0, saturates at STARVE_LIMIT, and clears on any B grant; at STARVE_LIMIT, B wins the next contended cycle.
REQ-020 Read return: exactly one cycle after a granted read, the owning port's rvalid=1 for one cycle with rdata=mem_q; the other port's rdata=0.
REQ-021 Granted writes produce no rvalid.
REQ-022 Back-to-back reads from alternating ports return in grant order, one per cycle, with no loss.
REQ-023 Ungranted request inputs are ignored; requesters hold their request until granted.

Reset
REQ-024 While resetn=0: state IDLE, counter 0, read-owner pipeline cleared; a_rvalid, b_rvalid, a_gnt and b_gnt all 0; mem_ceb=1, mem_web=1.
REQ-025 Reset during LOCK_B or with a read in flight discards the lock and the pending rvalid.

Configuration
REQ-026 Macro DMEM_ARB_STARVE_EN defined: the starvation counter and REQ-019 are compiled in.
REQ-027 Macro DMEM_ARB_STARVE_EN undefined: no counter exists, and A always wins contended IDLE cycles (strict priority).

Verification
REQ-028 a_req=1 read, addr 0x010, mem_q=0xDEADBEEF next cycle -> a_gnt=1, mem_ceb=0, mem_web=1, then a_rvalid=1 with a_rdata=0xDEADBEEF, b_rvalid=0.
REQ-029 a_req and b_req held at 1 continuously, STARVE_EN on, STARVE_LIMIT=4 -> A granted cycles 0-3, B granted cycle 4, A granted cycle 5.
REQ-030 Same stimulus as REQ-029 with STARVE_EN off -> b_gnt=0 for all 20 cycles.
REQ-031 B writes with b_lock=1 for 3 cycles while a_req=1 -> a_gnt=0 throughout; A granted the cycle after b_lock drops.
REQ-032 A read then B read on consecutive cycles -> a_rvalid then b_rvalid on consecutive cycles, each carrying its own mem_q.
REQ-033 resetn=0 asserted in LOCK_B with a read in flight -> next cycle: both rvalid 0, state IDLE, a_req granted once resetn=1.
